// File: rtl/circle_compositor_if.sv
// Scan, descriptor and pixel/collision signals between the VGA front end and the compositor.
interface circle_compositor_if #(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned RW      = 8
);
  logic                  i_pix_stb;
  logic [CW-1:0]         i_x;
  logic [CW-1:0]         i_y;
  logic                  i_active;
  logic                  i_hsync;
  logic                  i_vsync;
  logic                  i_frame_end;
  logic [NUM_OBJ*CW-1:0] i_cx;
  logic [NUM_OBJ*CW-1:0] i_cy;
  logic [NUM_OBJ*RW-1:0] i_r;
  logic [NUM_OBJ*12-1:0] i_rgb;
  logic [NUM_OBJ-1:0]    i_en;
  logic [3:0]            o_red;
  logic [3:0]            o_green;
  logic [3:0]            o_blue;
  logic                  o_hsync;
  logic                  o_vsync;
  logic [NUM_OBJ-1:0]    o_hit_mask;
  logic                  o_hit;
  logic [15:0]           o_hit_count;

  // Scan controller / animators side
  modport master (
    output i_pix_stb, i_x, i_y, i_active, i_hsync, i_vsync, i_frame_end,
    output i_cx, i_cy, i_r, i_rgb, i_en,
    input  o_red, o_green, o_blue, o_hsync, o_vsync, o_hit_mask, o_hit, o_hit_count
  );

  // Compositor side
  modport slave (
    input  i_pix_stb, i_x, i_y, i_active, i_hsync, i_vsync, i_frame_end,
    input  i_cx, i_cy, i_r, i_rgb, i_en,
    output o_red, o_green, o_blue, o_hsync, o_vsync, o_hit_mask, o_hit, o_hit_count
  );
endinterface

// File: rtl/circle_compositor.sv
// Three-stage strobe-gated circle compositor with fighting-box border and
// per-frame player/hazard collision reporting.
module circle_compositor #(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned CW      = 16,
  parameter int unsigned RW      = 8,
  parameter int unsigned BOX_X   = 245,
  parameter int unsigned BOX_Y   = 230,
  parameter int unsigned BOX_W   = 150,
  parameter int unsigned BOX_H   = 150,
  parameter int unsigned BOX_T   = 2,
  parameter logic [11:0] BOX_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB  = 12'h000
) (
  input logic                i_clk,
  input logic                i_rst,
  circle_compositor_if.slave bus
);

  localparam int unsigned DW   = CW + 1;
  localparam int unsigned SW   = 2 * CW + 2;
  localparam int unsigned CMPW = 2 * CW + 3;
  localparam int unsigned RRW  = 2 * RW;
  localparam int unsigned X_LO = BOX_X - BOX_T;
  localparam int unsigned X_HI = BOX_X + BOX_W + BOX_T;
  localparam int unsigned Y_LO = BOX_Y - BOX_T;
  localparam int unsigned Y_HI = BOX_Y + BOX_H + BOX_T;
  localparam int unsigned XI_HI = BOX_X + BOX_W;
  localparam int unsigned YI_HI = BOX_Y + BOX_H;

  // S1 registers
  logic signed [DW-1:0] s1_dx  [NUM_OBJ];
  logic signed [DW-1:0] s1_dy  [NUM_OBJ];
  logic [RW-1:0]        s1_r   [NUM_OBJ];
  logic [11:0]          s1_rgb [NUM_OBJ];
  logic [NUM_OBJ-1:0]   s1_en;
  logic [CW-1:0]        s1_x, s1_y;

  // S2 registers
  logic [SW-1:0]        s2_sqx [NUM_OBJ];
  logic [SW-1:0]        s2_sqy [NUM_OBJ];
  logic [RRW-1:0]       s2_rr  [NUM_OBJ];
  logic [11:0]          s2_rgb [NUM_OBJ];
  logic [NUM_OBJ-1:0]   s2_en;
  logic [CW-1:0]        s2_x, s2_y;

  // Sideband shift registers; the third stage is the output register itself
  logic [1:0]           act_sr, hs_sr, vs_sr;

  logic [NUM_OBJ-1:0]   acc;
  logic [CMPW-1:0]      sum_c [NUM_OBJ];
  logic [NUM_OBJ-1:0]   in_c;
  logic [NUM_OBJ-1:0]   contrib_c;
  logic [NUM_OBJ-1:0]   mask_c;
  logic                 border_c;
  logic [11:0]          pix_c;
  logic [31:0]          x_c, y_c;

  // S1: signed offsets from each centre, descriptors captured alongside
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
        s1_dx[k]  <= '0;
        s1_dy[k]  <= '0;
        s1_r[k]   <= '0;
        s1_rgb[k] <= '0;
      end
      s1_en <= '0;
      s1_x  <= '0;
      s1_y  <= '0;
    end else if (bus.i_pix_stb) begin
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
        s1_dx[k]  <= $signed({1'b0, bus.i_x} - {1'b0, bus.i_cx[k*CW +: CW]});
        s1_dy[k]  <= $signed({1'b0, bus.i_y} - {1'b0, bus.i_cy[k*CW +: CW]});
        s1_r[k]   <= bus.i_r[k*RW +: RW];
        s1_rgb[k] <= bus.i_rgb[k*12 +: 12];
      end
      s1_en <= bus.i_en;
      s1_x  <= bus.i_x;
      s1_y  <= bus.i_y;
    end
  end

  // S2: full-width squares of the offsets and of the radius
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
        s2_sqx[k] <= '0;
        s2_sqy[k] <= '0;
        s2_rr[k]  <= '0;
        s2_rgb[k] <= '0;
      end
      s2_en <= '0;
      s2_x  <= '0;
      s2_y  <= '0;
    end else if (bus.i_pix_stb) begin
      for (int k = 0; k < int'(NUM_OBJ); k++) begin
        s2_sqx[k] <= SW'(SW'(s1_dx[k]) * SW'(s1_dx[k]));
        s2_sqy[k] <= SW'(SW'(s1_dy[k]) * SW'(s1_dy[k]));
        s2_rr[k]  <= RRW'(s1_r[k]) * RRW'(s1_r[k]);
        s2_rgb[k] <= s1_rgb[k];
      end
      s2_en <= s1_en;
      s2_x  <= s1_x;
      s2_y  <= s1_y;
    end
  end

  // S3 combinational: inclusive circle test, border band, priority and collision terms
  always_comb begin
    in_c      = '0;
    contrib_c = '0;
    pix_c     = BG_RGB;
    x_c       = 32'(s2_x);
    y_c       = 32'(s2_y);
    for (int k = 0; k < int'(NUM_OBJ); k++) begin
      sum_c[k] = CMPW'(s2_sqx[k]) + CMPW'(s2_sqy[k]);
      in_c[k]  = s2_en[k] & (sum_c[k] <= CMPW'(s2_rr[k]));
    end
    border_c = (x_c >= X_LO) && (x_c < X_HI) && (y_c >= Y_LO) && (y_c < Y_HI) &&
               !((x_c >= BOX_X) && (x_c < XI_HI) && (y_c >= BOX_Y) && (y_c < YI_HI));
    if (border_c) pix_c = BOX_RGB;
    for (int k = int'(NUM_OBJ) - 1; k >= 0; k--) begin
      if (in_c[k]) pix_c = s2_rgb[k];
    end
    for (int k = 1; k < int'(NUM_OBJ); k++) begin
      contrib_c[k] = in_c[0] & in_c[k];
    end
    if (!act_sr[1]) begin
      pix_c     = 12'h000;
      contrib_c = '0;
    end
    mask_c = acc | contrib_c;
  end

  // S3 registers: pixel colour and delayed syncs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_sr      <= '0;
      hs_sr       <= '1;
      vs_sr       <= '1;
      bus.o_red   <= '0;
      bus.o_green <= '0;
      bus.o_blue  <= '0;
      bus.o_hsync <= 1'b1;
      bus.o_vsync <= 1'b1;
    end else if (bus.i_pix_stb) begin
      act_sr      <= {act_sr[0], bus.i_active};
      hs_sr       <= {hs_sr[0], bus.i_hsync};
      vs_sr       <= {vs_sr[0], bus.i_vsync};
      bus.o_red   <= pix_c[11:8];
      bus.o_green <= pix_c[7:4];
      bus.o_blue  <= pix_c[3:0];
      bus.o_hsync <= hs_sr[1];
      bus.o_vsync <= vs_sr[1];
    end
  end

  // Collision accumulation and frame-end reporting
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc             <= '0;
      bus.o_hit_mask  <= '0;
      bus.o_hit       <= 1'b0;
      bus.o_hit_count <= '0;
    end else begin
      bus.o_hit <= 1'b0;
      if (bus.i_pix_stb) begin
        if (bus.i_frame_end) begin
          bus.o_hit_mask <= mask_c;
          acc            <= '0;
          bus.o_hit      <= |mask_c;
          if ((|mask_c) && (bus.o_hit_count != 16'hFFFF))
            bus.o_hit_count <= bus.o_hit_count + 16'd1;
        end else begin
          acc <= mask_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_circle_compositor.sv
// Directed-vector bench for circle_compositor.
module tb_circle_compositor;

  localparam int unsigned NUM_OBJ = 4;
  localparam int unsigned CW      = 16;
  localparam int unsigned RW      = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  circle_compositor_if #(.NUM_OBJ(NUM_OBJ), .CW(CW), .RW(RW)) bus ();

  circle_compositor #(.NUM_OBJ(NUM_OBJ), .CW(CW), .RW(RW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb();
    return 32'({bus.o_red, bus.o_green, bus.o_blue});
  endfunction

  task automatic set_obj(input int k, input int cx, input int cy, input int r,
                         input logic [11:0] col, input logic en);
    bus.i_cx[k*CW +: CW]  = 16'(cx);
    bus.i_cy[k*CW +: CW]  = 16'(cy);
    bus.i_r[k*RW +: RW]   = 8'(r);
    bus.i_rgb[k*12 +: 12] = col;
    bus.i_en[k]           = en;
  endtask

  // One strobe; returns on the falling edge after the strobed rising edge
  task automatic pix(input int x, input int y, input logic act, input logic hs,
                     input logic vs, input logic fe);
    @(negedge clk);
    bus.i_x         = 16'(x);
    bus.i_y         = 16'(y);
    bus.i_active    = act;
    bus.i_hsync     = hs;
    bus.i_vsync     = vs;
    bus.i_frame_end = fe;
    bus.i_pix_stb   = 1'b1;
    @(negedge clk);
    bus.i_pix_stb   = 1'b0;
    bus.i_frame_end = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
    repeat (3) pix(x, y, 1'b1, 1'b1, 1'b1, 1'b0);
    check(tag, rgb(), 32'(exp));
  endtask

  task automatic flush();
    repeat (3) pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic end_frame();
    pix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_pix_stb   = 1'b0;
    bus.i_x         = '0;
    bus.i_y         = '0;
    bus.i_active    = 1'b0;
    bus.i_hsync     = 1'b1;
    bus.i_vsync     = 1'b1;
    bus.i_frame_end = 1'b0;
    bus.i_cx        = '0;
    bus.i_cy        = '0;
    bus.i_r         = '0;
    bus.i_rgb       = '0;
    bus.i_en        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Mid-line asynchronous reset
    set_obj(1, 10, 10, 3, 12'hF00, 1'b1);
    repeat (3) pix(10, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset_rgb", rgb(), 32'h0F00);
    check("pre_reset_hs", 32'(bus.o_hsync), 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_rgb", rgb(), 32'h0);
    check("rst_hs", 32'(bus.o_hsync), 32'h1);
    check("rst_vs", 32'(bus.o_vsync), 32'h1);
    check("rst_mask", 32'(bus.o_hit_mask), 32'h0);
    check("rst_hit", 32'(bus.o_hit), 32'h0);
    check("rst_count", 32'(bus.o_hit_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_obj(1, 10, 10, 3, 12'hF00, 1'b0);

    // Sync delay of three strobes
    pix(10, 10, 1'b1, 1'b0, 1'b1, 1'b0);
    pix(10, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hs_lat2", 32'(bus.o_hsync), 32'h1);
    pix(10, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    check("hs_d3a", 32'(bus.o_hsync), 32'h0);
    check("vs_d3a", 32'(bus.o_vsync), 32'h1);
    check("bg_after_rst", rgb(), 32'h000);
    pix(10, 10, 1'b1, 1'b0, 1'b1, 1'b0);
    check("hs_d3b", 32'(bus.o_hsync), 32'h1);
    check("vs_d3b", 32'(bus.o_vsync), 32'h0);

    // Circle edge pixels
    set_obj(1, 100, 100, 5, 12'hF00, 1'b1);
    probe("c1_105_100", 105, 100, 12'hF00);
    probe("c1_106_100", 106, 100, 12'h000);
    probe("c1_103_104", 103, 104, 12'hF00);
    probe("c1_104_104", 104, 104, 12'h000);
    set_obj(1, 100, 100, 5, 12'hF00, 1'b0);

    // Radius 0 and off-screen centre
    set_obj(2, 50, 60, 0, 12'h00F, 1'b1);
    set_obj(3, 65534, 10, 5, 12'h0FF, 1'b1);
    probe("r0_centre", 50, 60, 12'h00F);
    probe("r0_next", 51, 60, 12'h000);
    probe("no_wrap", 1, 10, 12'h000);
    set_obj(2, 50, 60, 0, 12'h00F, 1'b0);
    set_obj(3, 65534, 10, 5, 12'h0FF, 1'b0);
    flush();
    end_frame();
    check("nohit_mask", 32'(bus.o_hit_mask), 32'h0);
    check("nohit_count", 32'(bus.o_hit_count), 32'h0);

    // Heart over hazard
    set_obj(0, 200, 200, 5, 12'h0F0, 1'b1);
    set_obj(1, 200, 200, 5, 12'hF00, 1'b1);
    probe("heart_top", 200, 200, 12'h0F0);
    flush();
    check("mask_before_fe", 32'(bus.o_hit_mask), 32'h0);
    end_frame();
    check("hit_mask", 32'(bus.o_hit_mask), 32'h2);
    check("hit_pulse", 32'(bus.o_hit), 32'h1);
    check("hit_count1", 32'(bus.o_hit_count), 32'h1);
    @(negedge clk);
    check("hit_clear", 32'(bus.o_hit), 32'h0);

    // Disabled hazard neither draws nor collides
    set_obj(1, 200, 200, 5, 12'hF00, 1'b0);
    set_obj(0, 300, 300, 5, 12'h0F0, 1'b0);
    probe("dis_no_draw", 200, 200, 12'h000);
    set_obj(0, 200, 200, 5, 12'h0F0, 1'b1);
    probe("dis_heart", 200, 200, 12'h0F0);
    flush();
    end_frame();
    check("dis_mask", 32'(bus.o_hit_mask), 32'h0);
    check("dis_hit", 32'(bus.o_hit), 32'h0);
    check("dis_count", 32'(bus.o_hit_count), 32'h1);

    // Touching circles at the inclusive boundary, two hazards
    set_obj(0, 300, 100, 2, 12'h0F0, 1'b1);
    set_obj(1, 304, 100, 2, 12'hF00, 1'b1);
    set_obj(3, 302, 100, 0, 12'h00F, 1'b1);
    probe("touch_pix", 302, 100, 12'h0F0);
    flush();
    end_frame();
    check("touch_mask", 32'(bus.o_hit_mask), 32'hA);
    check("touch_count", 32'(bus.o_hit_count), 32'h2);
    set_obj(0, 300, 100, 2, 12'h0F0, 1'b0);
    set_obj(1, 304, 100, 2, 12'hF00, 1'b0);
    set_obj(3, 302, 100, 0, 12'h00F, 1'b0);

    // Border band
    probe("bd_243_230", 243, 230, 12'hFFF);
    probe("bd_396_300", 396, 300, 12'hFFF);
    probe("bd_245_230", 245, 230, 12'h000);
    probe("bd_244_382", 244, 382, 12'h000);
    probe("bd_242_230", 242, 230, 12'h000);
    probe("bd_396_381", 396, 381, 12'hFFF);

    // Inactive blanking and strobe freeze
    set_obj(0, 200, 200, 5, 12'h0F0, 1'b1);
    repeat (3) pix(200, 200, 1'b0, 1'b1, 1'b1, 1'b0);
    check("inactive_rgb", rgb(), 32'h000);
    probe("pre_freeze", 200, 200, 12'h0F0);
    @(negedge clk);
    bus.i_x     = 16'd0;
    bus.i_hsync = 1'b0;
    bus.i_vsync = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_rgb", rgb(), 32'h0F0);
    check("freeze_hs", 32'(bus.o_hsync), 32'h1);
    flush();
    end_frame();
    check("solo_mask", 32'(bus.o_hit_mask), 32'h0);

    // Drive the hit counter into saturation: every strobe is a hit frame end
    set_obj(1, 200, 200, 5, 12'hF00, 1'b1);
    @(negedge clk);
    bus.i_x = 16'd200; bus.i_y = 16'd200; bus.i_active = 1'b1;
    bus.i_hsync = 1'b1; bus.i_vsync = 1'b1;
    bus.i_frame_end = 1'b1; bus.i_pix_stb = 1'b1;
    repeat (65540) @(negedge clk);
    bus.i_pix_stb = 1'b0; bus.i_frame_end = 1'b0;
    check("sat_count", 32'(bus.o_hit_count), 32'hFFFF);
    repeat (3) pix(200, 200, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sat_hold", 32'(bus.o_hit_count), 32'hFFFF);
    check("sat_hit", 32'(bus.o_hit), 32'h1);

    // Reset mid-frame discards the accumulator
    probe("pre_rst_ovl", 200, 200, 12'h0F0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_rst_count", 32'(bus.o_hit_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    flush();
    end_frame();
    check("post_rst_mask", 32'(bus.o_hit_mask), 32'h0);
    check("post_rst_count", 32'(bus.o_hit_count), 32'h0);
    probe("first_frame", 200, 200, 12'h0F0);
    flush();
    end_frame();
    check("first_mask", 32'(bus.o_hit_mask), 32'h2);
    check("first_count", 32'(bus.o_hit_count), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
